clip_sequencer: RTL and testbench

- Sequences the two-clip audio record/playback datapath: gates the deserializer and serializer, and drives BRAM enables, write enables and the shared address.
- Tracks the recorded length of each clip and emits a one-second marker for the LED interface.
- Sits between the button synchronizer and the BRAM/deserializer/serializer blocks.
- Replaces the ad-hoc controller plus address counter pairing.

---
 rtl/clip_sequencer_if.sv | 40 ++++
 rtl/clip_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_clip_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clip_sequencer_if.sv
// Handshake and BRAM-control bundle between the clip sequencer and
// the button, deserializer, serializer and BRAM blocks.
interface clip_sequencer_if #(
    parameter int ADDR_WIDTH = 18
);
    logic                  record;
    logic                  play;
    logic                  clip_record_num;
    logic                  clip_play_num;
    logic                  des_done;
    logic                  ser_done;
    logic                  des_enable;
    logic                  ser_enable;
    logic                  ser_load;
    logic                  mem1_en;
    logic                  mem2_en;
    logic                  mem1_wen;
    logic                  mem2_wen;
    logic [ADDR_WIDTH-1:0] address;
    logic                  active_clip;
    logic                  recording;
    logic                  playing;
    logic                  second_marker;

    modport master (
        output record, play, clip_record_num, clip_play_num,
        output des_done, ser_done,
        input  des_enable, ser_enable, ser_load,
        input  mem1_en, mem2_en, mem1_wen, mem2_wen, address,
        input  active_clip, recording, playing, second_marker
    );

    modport slave (
        input  record, play, clip_record_num, clip_play_num,
        input  des_done, ser_done,
        output des_enable, ser_enable, ser_load,
        output mem1_en, mem2_en, mem1_wen, mem2_wen, address,
        output active_clip, recording, playing, second_marker
    );
endinterface

// File: rtl/clip_sequencer.sv
// Two-clip record/playback sequencer: drives deserializer/serializer
// gating, BRAM strobes and the shared address; tracks clip lengths.
module clip_sequencer #(
    parameter int ADDR_WIDTH      = 18,
    parameter int CLIP_DEPTH      = 200000,
    parameter int SAMPLES_PER_SEC = 48000
) (
    input logic              clock,
    input logic              reset,
    clip_sequencer_if.slave  bus
);
    localparam int LW = ADDR_WIDTH + 1;
    localparam int SW = $clog2(SAMPLES_PER_SEC + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(CLIP_DEPTH - 1);
    localparam logic [SW-1:0] SEC_TOP = SW'(SAMPLES_PER_SEC - 1);

    typedef enum logic [2:0] {
        IDLE, REC, PLAY_RD, PLAY_LAT, PLAY_LOAD, PLAY_WAIT
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [SW-1:0]         sec_q, sec_d;
    logic [LW-1:0]         len1_q, len1_d;
    logic [LW-1:0]         len2_q, len2_d;
    logic                  clip_q, clip_d;
    logic                  rec_prev_q, play_prev_q;

    logic                  des_en_q, des_en_d;
    logic                  ser_en_q, ser_en_d;
    logic                  ser_load_q, ser_load_d;
    logic                  mem1_en_q, mem1_en_d;
    logic                  mem2_en_q, mem2_en_d;
    logic                  mem1_wen_q, mem1_wen_d;
    logic                  mem2_wen_q, mem2_wen_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  rec_q, rec_d;
    logic                  playing_q, playing_d;
    logic                  marker_q, marker_d;

    logic          rec_edge, play_edge, in_play;
    logic          wr, rd, tick;
    logic [LW-1:0] sel_len, cur_len, ptr_nxt;

    always_comb begin
        rec_edge  = bus.record & ~rec_prev_q;
        play_edge = bus.play & ~play_prev_q;
        in_play   = (state_q == PLAY_RD) || (state_q == PLAY_LAT) ||
                    (state_q == PLAY_LOAD) || (state_q == PLAY_WAIT);
        sel_len   = bus.clip_play_num ? len2_q : len1_q;
        cur_len   = clip_q ? len2_q : len1_q;
        ptr_nxt   = {1'b0, ptr_q} + LW'(1);

        state_d = state_q;
        ptr_d   = ptr_q;
        sec_d   = sec_q;
        len1_d  = len1_q;
        len2_d  = len2_q;
        clip_d  = clip_q;
        wr      = 1'b0;
        tick    = 1'b0;

        // A play edge stops playback from any phase, ahead of ser_done.
        if (in_play && play_edge) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (rec_edge) begin
                        clip_d  = bus.clip_record_num;
                        ptr_d   = '0;
                        sec_d   = '0;
                        state_d = REC;
                        if (bus.clip_record_num) len2_d = '0;
                        else                     len1_d = '0;
                    end else if (play_edge) begin
                        clip_d = bus.clip_play_num;
                        if (sel_len != '0) begin
                            ptr_d   = '0;
                            sec_d   = '0;
                            state_d = PLAY_RD;
                        end
                    end
                end
                REC: begin
                    if (!bus.record) begin
                        state_d = IDLE;
                    end else if (bus.des_done) begin
                        wr   = 1'b1;
                        tick = 1'b1;
                        if (clip_q) len2_d = ptr_nxt;
                        else        len1_d = ptr_nxt;
                        if (ptr_q == LAST) state_d = IDLE;
                        else               ptr_d   = ptr_q + 1'b1;
                    end
                end
                PLAY_RD:   state_d = PLAY_LAT;
                PLAY_LAT:  state_d = PLAY_LOAD;
                PLAY_LOAD: state_d = PLAY_WAIT;
                PLAY_WAIT: begin
                    if (bus.ser_done) begin
                        tick = 1'b1;
                        if (ptr_nxt == cur_len) begin
                            state_d = IDLE;
                        end else begin
                            ptr_d   = ptr_q + 1'b1;
                            state_d = PLAY_RD;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        marker_d = 1'b0;
        if (tick) begin
            if (sec_q == SEC_TOP) begin
                sec_d    = '0;
                marker_d = 1'b1;
            end else begin
                sec_d = sec_q + 1'b1;
            end
        end

        // Outputs are registered off the next state so they line up
        // with the state they describe.
        rd         = (state_d == PLAY_RD);
        des_en_d   = (state_d == REC);
        rec_d      = (state_d == REC);
        ser_en_d   = (state_d == PLAY_WAIT);
        ser_load_d = (state_d == PLAY_LOAD);
        playing_d  = (state_d == PLAY_RD) || (state_d == PLAY_LAT) ||
                     (state_d == PLAY_LOAD) || (state_d == PLAY_WAIT);
        mem1_en_d  = (wr | rd) & ~clip_d;
        mem2_en_d  = (wr | rd) & clip_d;
        mem1_wen_d = wr & ~clip_d;
        mem2_wen_d = wr & clip_d;
        if (wr)             addr_d = ptr_q;
        else if (playing_d) addr_d = ptr_d;
        else                addr_d = '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            sec_q       <= '0;
            len1_q      <= '0;
            len2_q      <= '0;
            clip_q      <= 1'b0;
            rec_prev_q  <= 1'b0;
            play_prev_q <= 1'b0;
            des_en_q    <= 1'b0;
            ser_en_q    <= 1'b0;
            ser_load_q  <= 1'b0;
            mem1_en_q   <= 1'b0;
            mem2_en_q   <= 1'b0;
            mem1_wen_q  <= 1'b0;
            mem2_wen_q  <= 1'b0;
            addr_q      <= '0;
            rec_q       <= 1'b0;
            playing_q   <= 1'b0;
            marker_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            sec_q       <= sec_d;
            len1_q      <= len1_d;
            len2_q      <= len2_d;
            clip_q      <= clip_d;
            rec_prev_q  <= bus.record;
            play_prev_q <= bus.play;
            des_en_q    <= des_en_d;
            ser_en_q    <= ser_en_d;
            ser_load_q  <= ser_load_d;
            mem1_en_q   <= mem1_en_d;
            mem2_en_q   <= mem2_en_d;
            mem1_wen_q  <= mem1_wen_d;
            mem2_wen_q  <= mem2_wen_d;
            addr_q      <= addr_d;
            rec_q       <= rec_d;
            playing_q   <= playing_d;
            marker_q    <= marker_d;
        end
    end

    assign bus.des_enable    = des_en_q;
    assign bus.ser_enable    = ser_en_q;
    assign bus.ser_load      = ser_load_q;
    assign bus.mem1_en       = mem1_en_q;
    assign bus.mem2_en       = mem2_en_q;
    assign bus.mem1_wen      = mem1_wen_q;
    assign bus.mem2_wen      = mem2_wen_q;
    assign bus.address       = addr_q;
    assign bus.active_clip   = clip_q;
    assign bus.recording     = rec_q;
    assign bus.playing       = playing_q;
    assign bus.second_marker = marker_q;
endmodule

// File: tb/tb_clip_sequencer.sv
// Bench for clip_sequencer: behavioural model checked every cycle plus
// directed scenarios with literal expectations.
module tb_clip_sequencer;
    localparam int AW    = 4;
    localparam int DEPTH = 8;
    localparam int SPS   = 4;
    localparam int VW    = 11 + AW;

    localparam int M_IDLE = 0;
    localparam int M_REC  = 1;
    localparam int M_RD   = 2;
    localparam int M_LAT  = 3;
    localparam int M_LOAD = 4;
    localparam int M_WAIT = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;

    clip_sequencer_if #(.ADDR_WIDTH(AW)) bus ();

    clip_sequencer #(
        .ADDR_WIDTH(AW),
        .CLIP_DEPTH(DEPTH),
        .SAMPLES_PER_SEC(SPS)
    ) dut (
        .clock(clk),
        .reset(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(string name, longint act, longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    logic [VW-1:0] dut_vec;
    assign dut_vec = {bus.des_enable, bus.ser_enable, bus.ser_load,
                      bus.mem1_en, bus.mem2_en, bus.mem1_wen,
                      bus.mem2_wen, bus.active_clip, bus.recording,
                      bus.playing, bus.second_marker, bus.address};

    // Behavioural model: modes and sample counts from the rules
    bit            armed = 0;
    int            m_mode, m_ptr, m_sec;
    int            m_len[2];
    bit            m_clip, m_rp, m_pp;
    logic [VW-1:0] exp_vec;

    always @(posedge clk) begin
        bit redge, pedge, wr, mk, rd;
        int waddr, ea;
        if (rst) begin
            armed = 1;
            m_mode = M_IDLE; m_ptr = 0; m_sec = 0;
            m_len[0] = 0; m_len[1] = 0;
            m_clip = 0; m_rp = 0; m_pp = 0;
            exp_vec = '0;
        end else begin
            redge = bus.record && !m_rp;
            pedge = bus.play && !m_pp;
            m_rp = bus.record;
            m_pp = bus.play;
            wr = 0; mk = 0; waddr = 0;
            if (m_mode >= M_RD && pedge) begin
                m_mode = M_IDLE;
            end else begin
                case (m_mode)
                    M_IDLE: begin
                        if (redge) begin
                            m_clip = bus.clip_record_num;
                            m_ptr = 0; m_sec = 0;
                            m_len[m_clip] = 0;
                            m_mode = M_REC;
                        end else if (pedge) begin
                            m_clip = bus.clip_play_num;
                            if (m_len[m_clip] != 0) begin
                                m_ptr = 0; m_sec = 0;
                                m_mode = M_RD;
                            end
                        end
                    end
                    M_REC: begin
                        if (!bus.record) m_mode = M_IDLE;
                        else if (bus.des_done) begin
                            wr = 1;
                            waddr = m_ptr;
                            m_ptr++;
                            m_len[m_clip] = m_ptr;
                            m_sec++;
                            if (m_sec == SPS) begin m_sec = 0; mk = 1; end
                            if (m_ptr == DEPTH) m_mode = M_IDLE;
                        end
                    end
                    M_RD:   m_mode = M_LAT;
                    M_LAT:  m_mode = M_LOAD;
                    M_LOAD: m_mode = M_WAIT;
                    M_WAIT: begin
                        if (bus.ser_done) begin
                            m_ptr++;
                            m_sec++;
                            if (m_sec == SPS) begin m_sec = 0; mk = 1; end
                            m_mode = (m_ptr == m_len[m_clip]) ? M_IDLE : M_RD;
                        end
                    end
                    default: m_mode = M_IDLE;
                endcase
            end
            rd = (m_mode == M_RD);
            ea = wr ? waddr : (m_mode >= M_RD ? m_ptr : 0);
            exp_vec = {m_mode == M_REC, m_mode == M_WAIT,
                       m_mode == M_LOAD,
                       (wr || rd) && !m_clip, (wr || rd) && m_clip,
                       wr && !m_clip, wr && m_clip, m_clip,
                       m_mode == M_REC, m_mode >= M_RD, mk, AW'(ea)};
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            n_cmp++;
            if (dut_vec !== exp_vec) begin
                n_bad++;
                $display("FAIL cycle_outputs t=%0t: got %h expected %h",
                         $time, dut_vec, exp_vec);
            end
        end
    end

    // Monitor logs used by the literal checks
    int cyc = 0;
    int n_acc = 0;
    int w1[$], w2[$], rd_addr[$], rd_cyc[$], ld_cyc[$], mk_at[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.mem1_en || bus.mem2_en) n_acc++;
        if (bus.mem1_en && bus.mem1_wen) w1.push_back(int'(bus.address));
        if (bus.mem2_en && bus.mem2_wen) w2.push_back(int'(bus.address));
        if ((bus.mem1_en && !bus.mem1_wen) ||
            (bus.mem2_en && !bus.mem2_wen)) begin
            rd_addr.push_back(int'(bus.address));
            rd_cyc.push_back(cyc);
        end
        if (bus.ser_load) ld_cyc.push_back(cyc);
        if (bus.second_marker) mk_at.push_back(w2.size());
    end

    // Serializer stand-in: ser_done five cycles after each ser_load
    bit ser_auto = 0;
    int cd = 0;
    always @(negedge clk) begin
        bus.ser_done = 1'b0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) bus.ser_done = 1'b1;
        end
        if (ser_auto && bus.ser_load) cd = 5;
    end

    task automatic cw(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_logs();
        w1.delete(); w2.delete(); rd_addr.delete();
        rd_cyc.delete(); ld_cyc.delete(); mk_at.delete();
    endtask

    initial begin
        int k, acc0, ld0;
        bus.record = 0; bus.play = 0;
        bus.clip_record_num = 0; bus.clip_play_num = 0;
        bus.des_done = 0;
        rst = 1;
        cw(3);
        check("reset_outputs", dut_vec, 0);
        rst = 0;
        cw(1);

        // Basic record into clip0
        clear_logs();
        bus.clip_record_num = 0;
        bus.record = 1;
        cw(2);
        repeat (3) begin
            bus.des_done = 1; cw(1);
            bus.des_done = 0; cw(3);
        end
        bus.record = 0;
        cw(3);
        check("rec1_writes", w1.size(), 3);
        for (int i = 0; i < w1.size() && i < 3; i++)
            check("rec1_addr", w1[i], i);
        check("rec1_mem2_writes", w2.size(), 0);
        check("rec1_markers", mk_at.size(), 0);
        check("rec1_model_len", m_len[0], 3);

        // Playback of clip0
        clear_logs();
        ser_auto = 1;
        bus.clip_play_num = 0;
        bus.play = 1; cw(1);
        bus.play = 0;
        k = 0;
        while (bus.playing && k < 200) begin cw(1); k++; end
        check("play1_finished", bus.playing, 0);
        ser_auto = 0;
        check("play1_reads", rd_addr.size(), 3);
        check("play1_loads", ld_cyc.size(), 3);
        for (int i = 0; i < rd_addr.size() && i < 3; i++)
            check("play1_addr", rd_addr[i], i);
        for (int i = 0; i < rd_cyc.size() && i < ld_cyc.size(); i++)
            check("play1_load_gap", ld_cyc[i] - rd_cyc[i], 2);

        // Full clip1 with record held
        clear_logs();
        bus.clip_record_num = 1;
        bus.record = 1;
        cw(2);
        repeat (10) begin
            bus.des_done = 1; cw(1);
            bus.des_done = 0; cw(2);
        end
        check("full_recording_low", bus.recording, 0);
        check("full_writes", w2.size(), 8);
        for (int i = 0; i < w2.size() && i < 8; i++)
            check("full_addr", w2[i], i);
        check("full_mem1_writes", w1.size(), 0);
        check("full_markers", mk_at.size(), 2);
        if (mk_at.size() == 2) begin
            check("full_marker0_at", mk_at[0], 4);
            check("full_marker1_at", mk_at[1], 8);
        end
        check("full_model_len", m_len[1], 8);
        bus.record = 0;
        cw(2);

        // Simultaneous record and play edges: record wins
        bus.clip_record_num = 1;
        bus.clip_play_num = 0;
        bus.record = 1; bus.play = 1;
        cw(1);
        check("simul_recording", bus.recording, 1);
        check("simul_playing", bus.playing, 0);
        bus.record = 0; bus.play = 0;
        cw(2);

        // Play of empty clip1 makes no access
        acc0 = n_acc;
        bus.clip_play_num = 1;
        bus.play = 1; cw(1);
        bus.play = 0; cw(5);
        check("empty_play_access", n_acc - acc0, 0);
        check("empty_play_playing", bus.playing, 0);

        // Abort during PLAY_WAIT
        clear_logs();
        bus.clip_play_num = 0;
        bus.play = 1; cw(1);
        bus.play = 0;
        k = 0;
        while (!bus.ser_enable && k < 20) begin cw(1); k++; end
        check("abort_reached_wait", bus.ser_enable, 1);
        bus.play = 1; cw(1);
        check("abort_playing", bus.playing, 0);
        ld0 = ld_cyc.size();
        bus.play = 0;
        cw(15);
        check("abort_no_load", ld_cyc.size() - ld0, 0);
        check("abort_ser_enable", bus.ser_enable, 0);

        // Reset in the middle of a recording
        bus.clip_record_num = 0;
        bus.record = 1;
        cw(2);
        bus.des_done = 1; cw(1);
        bus.des_done = 0; cw(1);
        rst = 1; cw(1);
        check("midreset_outputs", dut_vec, 0);
        check("midreset_len1", m_len[0], 0);
        check("midreset_len2", m_len[1], 0);
        rst = 0;
        bus.record = 0;
        cw(1);
        acc0 = n_acc;
        bus.clip_play_num = 0;
        bus.play = 1; cw(1);
        bus.play = 0; cw(5);
        check("midreset_play_access", n_acc - acc0, 0);
        check("midreset_playing", bus.playing, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
